// File: rtl/psram_load_arbiter.sv
`default_nettype none
// ============================================================================
// psram_load_arbiter : lends the PSRAM pins to a host image loader while the
// PCH is idle and writes the loader's byte stream using SPI 0x02 commands.
// Revision : 1.0
// ============================================================================
module psram_load_arbiter #(
  parameter int GUARD_CYCLES = 16,
  parameter int STALL_MAX    = 255,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_in,
  input  logic        wr_req,
  input  logic [23:0] wr_addr,
  input  logic [7:0]  wr_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_data_valid,
  output logic        wr_data_ready,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_abort,
  output logic        ram_owner,
  output logic        ctl_clk,
  output logic        ctl_cs0,
  output logic        ctl_cs1,
  output logic        ctl_mosi
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GUARD = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_DESEL = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [SYNC_STAGES-1:0] cs_pipe;
  logic                   cs_sync;

  logic [2:0]    state, state_n;
  logic          chip_sel, chip_sel_n;
  logic [22:0]   addr_lo, addr_lo_n;
  logic [7:0]    len, len_n;
  logic [GW-1:0] guard_cnt, guard_cnt_n;
  logic [SW-1:0] stall_cnt, stall_cnt_n;
  logic [31:0]   shifter, shifter_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic          phase, phase_n;
  logic          in_data, in_data_n;
  logic          need_byte, need_byte_n;
  logic [7:0]    byte_cnt, byte_cnt_n;

  logic cs0_n, cs1_n, sclk_n, mosi_n, owner_n, busy_n, ready_n, done_n, abort_n;

  logic active, pch_abort, stalling, stall_timeout, kill;
  logic guard_done, chunk_last, last_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_pipe <= '1;
    end else begin
      cs_pipe[0] <= spi_cs_in;
      for (int i = 1; i < SYNC_STAGES; i++) cs_pipe[i] <= cs_pipe[i-1];
    end
  end
  assign cs_sync = cs_pipe[SYNC_STAGES-1];

  assign active        = (state == S_SEL) || (state == S_SHIFT) ||
                         (state == S_END) || (state == S_DESEL);
  assign pch_abort     = active && !cs_sync;
  assign stalling      = (state == S_SHIFT) && !phase && need_byte && !wr_data_valid;
  assign stall_timeout = stalling && (stall_cnt == SW'(STALL_MAX));
  assign kill          = pch_abort || stall_timeout;
  assign guard_done    = (state == S_GUARD) && cs_sync && (guard_cnt == GW'(GUARD_CYCLES - 1));
  assign chunk_last    = (state == S_SHIFT) && phase && (bit_cnt == 5'd0);
  assign last_byte     = in_data && (byte_cnt == len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      chip_sel      <= 1'b0;
      addr_lo       <= '0;
      len           <= '0;
      guard_cnt     <= '0;
      stall_cnt     <= '0;
      shifter       <= '0;
      bit_cnt       <= '0;
      phase         <= 1'b0;
      in_data       <= 1'b0;
      need_byte     <= 1'b0;
      byte_cnt      <= '0;
      ctl_cs0       <= 1'b1;
      ctl_cs1       <= 1'b1;
      ctl_clk       <= 1'b0;
      ctl_mosi      <= 1'b0;
      ram_owner     <= 1'b0;
      wr_busy       <= 1'b0;
      wr_data_ready <= 1'b0;
      wr_done       <= 1'b0;
      wr_abort      <= 1'b0;
    end else begin
      state         <= state_n;
      chip_sel      <= chip_sel_n;
      addr_lo       <= addr_lo_n;
      len           <= len_n;
      guard_cnt     <= guard_cnt_n;
      stall_cnt     <= stall_cnt_n;
      shifter       <= shifter_n;
      bit_cnt       <= bit_cnt_n;
      phase         <= phase_n;
      in_data       <= in_data_n;
      need_byte     <= need_byte_n;
      byte_cnt      <= byte_cnt_n;
      ctl_cs0       <= cs0_n;
      ctl_cs1       <= cs1_n;
      ctl_clk       <= sclk_n;
      ctl_mosi      <= mosi_n;
      ram_owner     <= owner_n;
      wr_busy       <= busy_n;
      wr_data_ready <= ready_n;
      wr_done       <= done_n;
      wr_abort      <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (wr_req) state_n = S_GUARD;
      S_GUARD: if (guard_done) state_n = S_SEL;
      S_SEL:   state_n = S_SHIFT;
      S_SHIFT: if (chunk_last && last_byte) state_n = S_END;
      S_END:   state_n = S_DESEL;
      S_DESEL: state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  always_comb begin
    chip_sel_n  = chip_sel;
    addr_lo_n   = addr_lo;
    len_n       = len;
    guard_cnt_n = guard_cnt;
    stall_cnt_n = stall_cnt;
    shifter_n   = shifter;
    bit_cnt_n   = bit_cnt;
    phase_n     = phase;
    in_data_n   = in_data;
    need_byte_n = need_byte;
    byte_cnt_n  = byte_cnt;
    cs0_n       = ctl_cs0;
    cs1_n       = ctl_cs1;
    sclk_n      = ctl_clk;
    mosi_n      = ctl_mosi;
    owner_n     = ram_owner;
    busy_n      = wr_busy;
    ready_n     = 1'b0;
    done_n      = 1'b0;
    abort_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_req) begin
          chip_sel_n  = wr_addr[23];
          addr_lo_n   = wr_addr[22:0];
          len_n       = wr_len;
          guard_cnt_n = '0;
          busy_n      = 1'b1;
        end
      end
      S_GUARD: begin
        if (!cs_sync) begin
          guard_cnt_n = '0;
        end else if (guard_done) begin
          owner_n     = 1'b1;
          shifter_n   = {8'h02, 1'b0, addr_lo};
          bit_cnt_n   = 5'd31;
          phase_n     = 1'b0;
          in_data_n   = 1'b0;
          need_byte_n = 1'b0;
          byte_cnt_n  = '0;
          stall_cnt_n = '0;
          guard_cnt_n = '0;
        end else begin
          guard_cnt_n = guard_cnt + GW'(1);
        end
      end
      S_SEL: begin
        cs0_n = chip_sel;
        cs1_n = !chip_sel;
      end
      S_SHIFT: begin
        if (!phase) begin
          sclk_n = 1'b0;
          // At a byte boundary the bit goes out straight from wr_data.
          if (need_byte) begin
            if (wr_data_valid) begin
              ready_n     = 1'b1;
              shifter_n   = {wr_data, 24'h000000};
              mosi_n      = wr_data[7];
              need_byte_n = 1'b0;
              stall_cnt_n = '0;
              phase_n     = 1'b1;
            end else begin
              stall_cnt_n = stall_cnt + SW'(1);
            end
          end else begin
            mosi_n  = shifter[31];
            phase_n = 1'b1;
          end
        end else begin
          sclk_n    = 1'b1;
          shifter_n = {shifter[30:0], 1'b0};
          phase_n   = 1'b0;
          if (bit_cnt == 5'd0) begin
            if (!last_byte) begin
              need_byte_n = 1'b1;
              bit_cnt_n   = 5'd7;
            end
            if (in_data) byte_cnt_n = byte_cnt + 8'd1;
            in_data_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt - 5'd1;
          end
        end
      end
      S_END: begin
        sclk_n = 1'b0;
        mosi_n = 1'b0;
      end
      S_DESEL: begin
        cs0_n = 1'b1;
        cs1_n = 1'b1;
      end
      S_FIN: begin
        owner_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: ;
    endcase
    if (kill) begin
      cs0_n   = 1'b1;
      cs1_n   = 1'b1;
      sclk_n  = 1'b0;
      mosi_n  = 1'b0;
      owner_n = 1'b0;
      busy_n  = 1'b0;
      ready_n = 1'b0;
      abort_n = 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_psram_load_arbiter.sv
`default_nettype none
// Directed bench for psram_load_arbiter: table of complete writes plus
// hand-written guard, preemption, stall and reset sequences.
module tb_psram_load_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_in = 1'b1;
  logic        wr_req = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [7:0]  wr_len = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_data_valid = 1'b1;
  logic        wr_data_ready, wr_busy, wr_done, wr_abort, ram_owner;
  logic        ctl_clk, ctl_cs0, ctl_cs1, ctl_mosi;

  psram_load_arbiter #(
    .GUARD_CYCLES(16),
    .STALL_MAX(255),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .spi_cs_in(spi_cs_in),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .wr_busy(wr_busy), .wr_done(wr_done),
    .wr_abort(wr_abort), .ram_owner(ram_owner), .ctl_clk(ctl_clk),
    .ctl_cs0(ctl_cs0), .ctl_cs1(ctl_cs1), .ctl_mosi(ctl_mosi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    int          edges;
    bit          cs1;
    logic [63:0] bits;
  } vec_t;

  vec_t vecs[4];

  int total = 0;
  int failed = 0;
  int edges, cs0_edges, cs1_edges, cs0_low, cs1_low, ready_cnt, done_cnt, abort_cnt;
  int owner_seen, cs0_falls, low_run, max_low_run;
  logic [63:0] cap;
  logic prev_clk = 1'b0;
  logic prev_cs0 = 1'b1;
  logic [31:0] tx_data = '0;
  int idx = 0;
  int drop_after = -1;
  int drop_len = 0;
  int drop = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] tx_byte(input int k);
    logic [31:0] d;
    d = tx_data << (8 * k);
    return d[31:24];
  endfunction

  task automatic clr();
    edges = 0; cs0_edges = 0; cs1_edges = 0; cs0_low = 0; cs1_low = 0;
    ready_cnt = 0; done_cnt = 0; abort_cnt = 0; owner_seen = 0; cs0_falls = 0;
    low_run = 0; max_low_run = 0; cap = '0;
  endtask

  // One clock: observe outputs on the falling edge, then feed the loader side.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      if (ctl_clk && !prev_clk) begin
        edges++;
        cap = {cap[62:0], ctl_mosi};
        if (!ctl_cs0) cs0_edges++;
        if (!ctl_cs1) cs1_edges++;
      end
      if (!ctl_cs0) cs0_low++;
      if (!ctl_cs1) cs1_low++;
      if (prev_cs0 && !ctl_cs0) cs0_falls++;
      if (!ctl_cs0 && !ctl_clk) low_run++; else low_run = 0;
      if (low_run > max_low_run) max_low_run = low_run;
      if (wr_data_ready) ready_cnt++;
      if (wr_done) done_cnt++;
      if (wr_abort) abort_cnt++;
      if (ram_owner) owner_seen++;
    end
    prev_clk = ctl_clk;
    prev_cs0 = ctl_cs0;
    #1;
    if (wr_data_ready) begin
      idx++;
      if (idx == drop_after) drop = drop_len;
    end
    wr_data = tx_byte(idx);
    if (drop > 0) begin
      wr_data_valid = 1'b0;
      drop--;
    end else begin
      wr_data_valid = 1'b1;
    end
  endtask

  task automatic start(input logic [23:0] a, input logic [7:0] l, input logic [31:0] d,
                       input int da, input int dl);
    clr();
    tx_data = d; idx = 0; drop_after = da; drop_len = dl; drop = 0;
    wr_data = d[31:24];
    wr_addr = a; wr_len = l; wr_req = 1'b1;
    step();
    wr_req = 1'b0;
  endtask

  task automatic run(input int max_cyc, output int n);
    n = 0;
    while (!wr_done && !wr_abort && n < max_cyc) begin
      step();
      n++;
    end
    check("finished within budget", 64'(n < max_cyc), 64'd1);
  endtask

  task automatic do_vec(input int i, input string tag);
    vec_t v;
    logic [63:0] m;
    int n, b;
    v = vecs[i];
    m = (v.edges >= 64) ? '1 : ((64'd1 << v.edges) - 64'd1);
    b = 32 + 8 * (int'(v.len) + 1);
    start(v.addr, v.len, v.data, -1, 0);
    check({tag, " busy after req"}, 64'(wr_busy), 64'd1);
    run(3000, n);
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " abort pulses"}, 64'(abort_cnt), 64'd0);
    check({tag, " sclk edges"}, 64'(edges), 64'(v.edges));
    check({tag, " edges on selected cs"}, 64'(v.cs1 ? cs1_edges : cs0_edges), 64'(v.edges));
    check({tag, " other cs low cycles"}, 64'(v.cs1 ? cs0_low : cs1_low), 64'd0);
    check({tag, " ready pulses"}, 64'(ready_cnt), 64'(int'(v.len) + 1));
    check({tag, " mosi bits"}, cap & m, v.bits);
    check({tag, " owner/busy released"}, {62'd0, ram_owner, wr_busy}, 64'd0);
    check({tag, " cycle count"}, 64'((n >= 2 * b + 16) && (n <= 2 * b + 21)), 64'd1);
  endtask

  initial begin
    int n, k;
    vecs[0] = '{24'h012345, 8'd0, 32'hA5000000, 40, 1'b0, 64'h0000_0002_0123_45A5};
    vecs[1] = '{24'h800010, 8'd3, 32'h11223344, 64, 1'b1, 64'h0200_0010_1122_3344};
    vecs[2] = '{24'h7FFFFF, 8'd1, 32'hDEAD0000, 48, 1'b0, 64'h0000_027F_FFFF_DEAD};
    vecs[3] = '{24'hFFFFFE, 8'd1, 32'h5AC30000, 48, 1'b1, 64'h0000_027F_FFFE_5AC3};
    clr();

    repeat (3) step();
    check("reset outputs",
          {55'd0, ctl_cs0, ctl_cs1, ctl_clk, ctl_mosi, ram_owner, wr_busy, wr_data_ready, wr_done, wr_abort},
          64'b1_1000_0000);
    reset = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 4; i++) begin
      do_vec(i, $sformatf("vec%0d", i));
      repeat (3) step();
    end

    // Guard: PCH keeps pulsing !CS, ownership must never be taken.
    start(24'h000200, 8'd0, 32'h3C000000, -1, 0);
    for (int i = 0; i < 100; i++) begin
      spi_cs_in = (i % 10 == 9) ? 1'b0 : 1'b1;
      step();
    end
    check("guard owner while pch toggles", 64'(owner_seen), 64'd0);
    check("guard cs while pch toggles", 64'(cs0_low + cs1_low), 64'd0);
    spi_cs_in = 1'b0;
    step();
    spi_cs_in = 1'b1;
    repeat (17) step();
    check("guard owner one cycle early", 64'(ram_owner), 64'd0);
    step();
    check("guard owner on time", 64'(ram_owner), 64'd1);
    run(3000, n);
    check("guard txn done", 64'(done_cnt), 64'd1);
    check("guard txn bits", cap & 64'hFF_FFFF_FFFF, 64'h0000_0002_0002_003C);
    repeat (3) step();

    // PCH preemption during the second data byte.
    start(24'h000300, 8'd3, 32'hCAFEBABE, -1, 0);
    n = 0;
    while (ready_cnt < 2 && n < 2000) begin
      step();
      n++;
    end
    repeat (3) step();
    spi_cs_in = 1'b0;
    k = 0;
    while (!wr_abort && k < 4) begin
      step();
      k++;
    end
    check("preempt latency within 3", 64'(k <= 3), 64'd1);
    check("preempt pins released",
          {60'd0, ctl_cs0, ctl_clk, ram_owner, wr_busy}, 64'b1000);
    repeat (5) step();
    check("preempt abort pulses", 64'(abort_cnt), 64'd1);
    check("preempt no done", 64'(done_cnt), 64'd0);
    spi_cs_in = 1'b1;
    repeat (3) step();

    // Short stall between bytes: clock parked low, !CS held, transfer completes.
    start(24'h000100, 8'd2, 32'hABCDEF00, 1, 26);
    run(3000, n);
    check("stall10 done", 64'(done_cnt), 64'd1);
    check("stall10 clk parked", 64'(max_low_run >= 10), 64'd1);
    check("stall10 single cs frame", 64'(cs0_falls), 64'd1);
    check("stall10 bits", cap & 64'hFF_FFFF_FFFF_FFFF, 64'h0002_0001_00AB_CDEF);
    check("stall10 ready pulses", 64'(ready_cnt), 64'd3);
    repeat (3) step();

    // Stall beyond the limit: aborts.
    start(24'h000080, 8'd3, 32'h11223344, 1, 1000);
    run(3000, n);
    check("stall timeout abort", 64'(abort_cnt), 64'd1);
    check("stall timeout no done", 64'(done_cnt), 64'd0);
    check("stall timeout length", 64'(max_low_run >= 255 && max_low_run <= 258), 64'd1);
    check("stall timeout pins", {60'd0, ctl_cs0, ctl_clk, ram_owner, wr_busy}, 64'b1000);
    drop = 0;
    repeat (3) step();

    // Asynchronous reset in the middle of shifting.
    start(24'h000040, 8'd3, 32'h11223344, -1, 0);
    n = 0;
    while (edges < 10 && n < 500) begin
      step();
      n++;
    end
    check("pre-reset shifting", {62'd0, 1'(edges >= 10), ctl_cs0}, 64'b10);
    reset = 1'b1;
    #1;
    check("reset mid-shift outputs",
          {55'd0, ctl_cs0, ctl_cs1, ctl_clk, ctl_mosi, ram_owner, wr_busy, wr_data_ready, wr_done, wr_abort},
          64'b1_1000_0000);
    step();
    reset = 1'b0;
    repeat (2) step();
    do_vec(0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", total, failed);
    $finish;
  end
endmodule
`default_nettype wire
